// File: rtl/svm_job_sequencer.sv
// Launches one SVM classification job per rising edge of the software start level,
// latches the result and keeps sticky status. The optional watchdog is enabled by SVM_WATCHDOG_EN.
module svm_job_sequencer #(
    parameter int                  CNT_WIDTH = 16,
    parameter int                  TO_WIDTH  = 24,
    parameter logic [TO_WIDTH-1:0] TO_CYCLES = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_axi_i,
    input  logic                 clear_axi_i,
    output logic                 start_svm_o,
    input  logic                 ready_svm_i,
    input  logic [3:0]           cl_num_svm_i,
    output logic [3:0]           cl_num_axi_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 irq_o,
    output logic [CNT_WIDTH-1:0] job_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_reg;
    logic                 start_q_reg;
    logic                 start_arm_reg;
    logic                 start_svm_reg;
    logic [3:0]           cl_num_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic                 irq_reg;
    logic [CNT_WIDTH-1:0] job_cnt_reg;
    logic                 start_req;
    logic                 wd_expired;

    // start_arm_reg blocks a launch until start has been seen low once after reset,
    // so a level left high by software across reset cannot start a job.
    assign start_req = start_axi_i & ~start_q_reg & start_arm_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            start_q_reg   <= 1'b0;
            start_arm_reg <= 1'b0;
        end else begin
            start_q_reg <= start_axi_i;
            if (!start_axi_i) begin
                start_arm_reg <= 1'b1;
            end
        end
    end

`ifdef SVM_WATCHDOG_EN
    logic [TO_WIDTH-1:0] wd_reg;

    // Held at zero while idle, so it starts from zero on every entry to START.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            wd_reg <= '0;
        end else if (state_reg == ST_START || state_reg == ST_BUSY) begin
            wd_reg <= wd_reg + TO_WIDTH'(1);
        end
    end

    assign wd_expired = (wd_reg == TO_CYCLES - TO_WIDTH'(1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            start_svm_reg <= 1'b0;
            cl_num_reg    <= 4'd0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            irq_reg       <= 1'b0;
            job_cnt_reg   <= '0;
        end else begin
            irq_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    start_svm_reg <= 1'b0;
                    if (start_req && ready_svm_i) begin
                        state_reg <= ST_START;
                        done_reg  <= 1'b0;
                        err_reg   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (wd_expired) begin
                        state_reg     <= ST_IDLE;
                        start_svm_reg <= 1'b0;
                        err_reg       <= 1'b1;
                        irq_reg       <= 1'b1;
                    end else if (!ready_svm_i) begin
                        state_reg     <= ST_BUSY;
                        start_svm_reg <= 1'b0;
                    end else begin
                        start_svm_reg <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    start_svm_reg <= 1'b0;
                    // A result arriving on the timeout cycle still counts as completion.
                    if (ready_svm_i) begin
                        state_reg <= ST_DONE;
                    end else if (wd_expired) begin
                        state_reg <= ST_IDLE;
                        err_reg   <= 1'b1;
                        irq_reg   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    start_svm_reg <= 1'b0;
                    cl_num_reg    <= cl_num_svm_i;
                    done_reg      <= 1'b1;
                    irq_reg       <= 1'b1;
                    job_cnt_reg   <= job_cnt_reg + CNT_WIDTH'(1);
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    start_svm_reg <= 1'b0;
                end
            endcase

            // Clear overrides any status set in the same cycle; result and count still update.
            if (clear_axi_i) begin
                done_reg <= 1'b0;
                err_reg  <= 1'b0;
                irq_reg  <= 1'b0;
            end
        end
    end

    assign start_svm_o  = start_svm_reg;
    assign cl_num_axi_o = cl_num_reg;
    assign done_o       = done_reg;
    assign err_o        = err_reg;
    assign irq_o        = irq_reg;
    assign job_cnt_o    = job_cnt_reg;
    assign state_o      = state_reg;
    assign busy_o       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_svm_job_sequencer.sv
// Directed bench for svm_job_sequencer with a small behavioural SVM core model.
module tb_svm_job_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_axi_i;
    logic       clear_axi_i;
    logic       start_svm_o;
    logic       ready_svm_i;
    logic [3:0] cl_num_svm_i;
    logic [3:0] cl_num_axi_o;
    logic       done_o;
    logic       err_o;
    logic       busy_o;
    logic       irq_o;
    logic [3:0] job_cnt_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // core model state
    logic core_ready = 1'b1;
    logic core_busy  = 1'b0;
    logic force_low  = 1'b0;
    int   core_cnt   = 0;
    int   compute_n  = 20;
    logic [3:0] cl_val = 4'd0;

    always #5 clk = ~clk;

    svm_job_sequencer #(
        .CNT_WIDTH(4),
        .TO_WIDTH (24),
        .TO_CYCLES(24'd50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_axi_i (start_axi_i),
        .clear_axi_i (clear_axi_i),
        .start_svm_o (start_svm_o),
        .ready_svm_i (ready_svm_i),
        .cl_num_svm_i(cl_num_svm_i),
        .cl_num_axi_o(cl_num_axi_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .irq_o       (irq_o),
        .job_cnt_o   (job_cnt_o),
        .state_o     (state_o)
    );

    assign ready_svm_i  = core_ready & ~force_low;
    assign cl_num_svm_i = cl_val;

    // Core drops ready the edge after it sees start, stays low compute_n cycles.
    always @(posedge clk) begin
        if (!reset) begin
            core_ready <= 1'b1;
            core_busy  <= 1'b0;
            core_cnt   <= 0;
        end else if (core_busy) begin
            if (core_cnt == compute_n - 1) begin
                core_ready <= 1'b1;
                core_busy  <= 1'b0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end else if (start_svm_o && ready_svm_i) begin
            core_ready <= 1'b0;
            core_busy  <= 1'b1;
            core_cnt   <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %0d %s: observed %0h expected %0h", checks, tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic run_job(input string tag);
        int guard;
        start_axi_i = 1'b0;
        tick(1);
        start_axi_i = 1'b1;
        tick(1);
        guard = 0;
        while (state_o !== 2'd3 && guard < 200) begin
            tick(1);
            guard++;
        end
        if (guard >= 200) begin
            chk({tag, "_reach_done"}, {30'd0, state_o}, 32'd3);
        end
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset       = 1'b0;
        start_axi_i = 1'b1;
        clear_axi_i = 1'b0;
        @(negedge clk);
        tick(3);

        // Reset state
        chk("rst_state",   {30'd0, state_o}, 32'd0);
        chk("rst_start",   {31'd0, start_svm_o}, 32'd0);
        chk("rst_busy",    {31'd0, busy_o}, 32'd0);
        chk("rst_done",    {31'd0, done_o}, 32'd0);
        chk("rst_err",     {31'd0, err_o}, 32'd0);
        chk("rst_irq",     {31'd0, irq_o}, 32'd0);
        chk("rst_cnt",     {28'd0, job_cnt_o}, 32'd0);
        chk("rst_cl",      {28'd0, cl_num_axi_o}, 32'd0);

        // Start held high through reset release must not launch
        reset = 1'b1;
        tick(4);
        chk("held_state", {30'd0, state_o}, 32'd0);
        chk("held_start", {31'd0, start_svm_o}, 32'd0);
        chk("held_busy",  {31'd0, busy_o}, 32'd0);

        // Job 1: latency and completion
        cl_val    = 4'd7;
        compute_n = 20;
        start_axi_i = 1'b0;
        tick(1);
        start_axi_i = 1'b1;
        tick(1);
        chk("j1_e0_state", {30'd0, state_o}, 32'd1);
        chk("j1_e0_start", {31'd0, start_svm_o}, 32'd0);
        tick(1);
        chk("j1_e1_start", {31'd0, start_svm_o}, 32'd1);
        tick(1);
        chk("j1_e2_ready", {31'd0, ready_svm_i}, 32'd0);
        chk("j1_e2_start", {31'd0, start_svm_o}, 32'd1);
        tick(1);
        chk("j1_e3_state", {30'd0, state_o}, 32'd2);
        chk("j1_e3_start", {31'd0, start_svm_o}, 32'd0);
        chk("j1_e3_busy",  {31'd0, busy_o}, 32'd1);
        tick(20);
        chk("j1_done_state", {30'd0, state_o}, 32'd3);
        chk("j1_done_irq",   {31'd0, irq_o}, 32'd0);
        tick(1);
        chk("j1_state", {30'd0, state_o}, 32'd0);
        chk("j1_cl",    {28'd0, cl_num_axi_o}, 32'd7);
        chk("j1_done",  {31'd0, done_o}, 32'd1);
        chk("j1_irq",   {31'd0, irq_o}, 32'd1);
        chk("j1_cnt",   {28'd0, job_cnt_o}, 32'd1);
        chk("j1_busy",  {31'd0, busy_o}, 32'd0);
        tick(1);
        chk("j1_irq_end", {31'd0, irq_o}, 32'd0);
        chk("j1_done_sticky", {31'd0, done_o}, 32'd1);

        // Job 2: second edge in BUSY ignored, clear in DONE cycle wins
        cl_val = 4'hA;
        start_axi_i = 1'b0;
        tick(1);
        start_axi_i = 1'b1;
        tick(1);
        chk("j2_done_cleared", {31'd0, done_o}, 32'd0);
        tick(3);
        chk("j2_busy_state", {30'd0, state_o}, 32'd2);
        start_axi_i = 1'b0;
        tick(1);
        start_axi_i = 1'b1;
        tick(1);
        chk("j2_edge_ignored", {30'd0, state_o}, 32'd2);
        tick(18);
        chk("j2_done_state", {30'd0, state_o}, 32'd3);
        clear_axi_i = 1'b1;
        tick(1);
        clear_axi_i = 1'b0;
        chk("j2_done", {31'd0, done_o}, 32'd0);
        chk("j2_cl",   {28'd0, cl_num_axi_o}, 32'hA);
        chk("j2_cnt",  {28'd0, job_cnt_o}, 32'd2);
        chk("j2_state", {30'd0, state_o}, 32'd0);
        tick(3);
        chk("j2_no_queue_state", {30'd0, state_o}, 32'd0);
        chk("j2_no_queue_busy",  {31'd0, busy_o}, 32'd0);

        // Start edge while core not ready is dropped
        force_low = 1'b1;
        start_axi_i = 1'b0;
        tick(1);
        start_axi_i = 1'b1;
        tick(1);
        chk("nr_state", {30'd0, state_o}, 32'd0);
        chk("nr_start", {31'd0, start_svm_o}, 32'd0);
        chk("nr_busy",  {31'd0, busy_o}, 32'd0);
        tick(2);
        chk("nr_state_later", {30'd0, state_o}, 32'd0);
        chk("nr_start_later", {31'd0, start_svm_o}, 32'd0);
        force_low = 1'b0;
        tick(2);
        chk("nr_no_relaunch", {30'd0, state_o}, 32'd0);

        // Counter wrap with CNT_WIDTH=4
        compute_n = 2;
        for (int j = 0; j < 13; j++) begin
            cl_val = 4'(j);
            run_job("wrap");
        end
        chk("wrap_15", {28'd0, job_cnt_o}, 32'd15);
        chk("wrap_cl", {28'd0, cl_num_axi_o}, 32'd12);
        run_job("wrap");
        chk("wrap_0", {28'd0, job_cnt_o}, 32'd0);
        run_job("wrap");
        chk("wrap_1", {28'd0, job_cnt_o}, 32'd1);
        chk("wrap_err", {31'd0, err_o}, 32'd0);

`ifdef SVM_WATCHDOG_EN
        // Ready returns on the timeout cycle: completion wins
        compute_n = 47;
        cl_val = 4'd3;
        start_axi_i = 1'b0;
        tick(1);
        start_axi_i = 1'b1;
        tick(1);
        tick(49);
        chk("wdc_state_busy", {30'd0, state_o}, 32'd2);
        tick(1);
        chk("wdc_state_done", {30'd0, state_o}, 32'd3);
        tick(1);
        chk("wdc_done", {31'd0, done_o}, 32'd1);
        chk("wdc_err",  {31'd0, err_o}, 32'd0);
        chk("wdc_cnt",  {28'd0, job_cnt_o}, 32'd2);
        chk("wdc_cl",   {28'd0, cl_num_axi_o}, 32'd3);

        // Core never returns: timeout after 50 cycles
        compute_n = 1000;
        start_axi_i = 1'b0;
        tick(1);
        start_axi_i = 1'b1;
        tick(1);
        tick(49);
        chk("wdt_state_busy", {30'd0, state_o}, 32'd2);
        chk("wdt_err_early",  {31'd0, err_o}, 32'd0);
        tick(1);
        chk("wdt_state", {30'd0, state_o}, 32'd0);
        chk("wdt_err",   {31'd0, err_o}, 32'd1);
        chk("wdt_irq",   {31'd0, irq_o}, 32'd1);
        chk("wdt_start", {31'd0, start_svm_o}, 32'd0);
        chk("wdt_done",  {31'd0, done_o}, 32'd0);
        chk("wdt_cnt",   {28'd0, job_cnt_o}, 32'd2);
        tick(1);
        chk("wdt_irq_end", {31'd0, irq_o}, 32'd0);
        chk("wdt_err_sticky", {31'd0, err_o}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
